multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Sequencer that performs WORDS×N-bit add/subtract operations by streaming one N-bit word per cycle, least-significant word first, through an external combinational `ripple_carry_adder` instance of width N. It sits directly around the adder. It drives the adder's A/B/Cin from the incoming operand stream and the stored inter-word carry. It registers the adder's Sum/Cout into an output word stream, with valid/ready handshakes on both sides.

## Interface
- N, 4: word width; must match the attached adder.
- WORDS, 4: words per operation, ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand word present.
- in_ready  out  1  block accepts the word this cycle.
- in_a  in  N  operand A word.
- in_b  in  N  operand B word.
- in_sub  in  1  1 = A−B; sampled only on the first word of an operation.
- in_cin  in  1  carry-in for the first word of an add; ignored for subtract.
- add_a  out  N  to adder A.
- add_b  out  N  to adder B.
- add_cin  out  1  to adder Cin.
- add_sum  in  N  from adder Sum.
- add_cout  in  1  from adder Cout.
- out_valid  out  1  result word present.
- out_ready  in  1  consumer accepts the result word.
- out_sum  out  N  result word.
- out_last  out  1  result word is word WORDS−1 of its operation.
- out_cout  out  1  final carry-out; meaningful when out_last=1, else 0.
- out_ovf  out  1  signed overflow of the full operation; meaningful when out_last=1, else 0.

## Operation
- The FSM has two states.
  - S_IDLE: the next accepted word is word 0.
  - S_RUN: mid-operation, word index idx is in 1..WORDS−1.
- Accept condition: in_valid & in_ready.
- in_ready = !rst & (!out_valid | out_ready). This is a single output register that passes data through when drained in the same cycle.
- op_sub_eff: in S_IDLE it is in_sub; in S_RUN it is op_sub, the registered copy of in_sub captured at word 0.
- Combinational adder drive:
  - add_a = in_a.
  - add_b = op_sub_eff ? ~in_b : in_b.
  - add_cin, word 0: op_sub_eff ? 1 : in_cin.
  - add_cin, other words: carry_r.
- On accept:
  - out_sum ← add_sum, out_valid ← 1.
  - carry_r ← add_cout.
  - out_last ← (idx==WORDS−1).
- On accept of the last word:
  - out_cout ← add_cout.
  - out_ovf ← (in_a[N−1] == add_b[N−1]) & (add_sum[N−1] != in_a[N−1]).
- On accept of a non-last word, out_cout and out_ovf are set to 0.
- State transitions:
  - S_IDLE, accept, WORDS==1: stay in S_IDLE.
  - S_IDLE, accept, WORDS>1: go to S_RUN with idx←1 and op_sub←in_sub.
  - S_RUN, accept, idx<WORDS−1: idx←idx+1.
  - S_RUN, accept, idx==WORDS−1: go to S_IDLE with idx←0.
  - No accept: state, idx and carry_r hold.
- out_valid clears when out_ready=1 and no new word is accepted in that cycle.
- Subtract semantics: out_cout=1 means no borrow (A ≥ B unsigned).
- The adder path is purely combinational. The result word appears one cycle after the accepting edge.

## Timing
- Reset values, applied at the first rising edge with rst=1:
  - state S_IDLE, idx 0, carry_r 0, op_sub 0.
  - out_valid 0, out_sum 0, out_last 0, out_cout 0, out_ovf 0.
  - in_ready is held 0 while rst=1.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 word per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_sum, out_last, out_cout and out_ovf are held stable.
  - in_ready=0, and no internal state changes.
- Simultaneous drain and accept in one cycle: the register is overwritten with the new word. out_valid stays 1 and there is no bubble.
- Reset mid-operation abandons the partial operation. The next accepted word is word 0 and uses in_cin/in_sub.
- Gaps (in_valid=0) between words of one operation are allowed. carry_r and idx are retained across them.

## Test plan
- Add, N=4, WORDS=4, out_ready=1:
  - Stimulus: A=0x1234, B=0x0FFF (words LS-first 4,3,2,1 / F,F,F,0), in_sub=0, in_cin=0.
  - Required: out_sum 3,3,2,2 on consecutive cycles, out_last only on word 4, out_cout=0, out_ovf=0.
- Subtract:
  - Stimulus: A=0x1000, B=0x0001, in_sub=1.
  - Required: out_sum F,F,F,0, out_cout=1, out_ovf=0.
  - Also: with in_sub toggled on words 1–3, the result is unchanged.
- Overflow and carry:
  - 0x7FFF+0x0001 → 0x8000, out_ovf=1, out_cout=0.
  - 0xFFFF+0x0001 → 0x0000, out_cout=1, out_ovf=0.
  - With in_cin=1: 0x0000+0x0000 → 0x0001.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles after word 1 of an add.
  - Required: in_ready=0, out_sum stable; after release the stream completes with the same result as with no stall, and no word is dropped or duplicated.
- Reset mid-operation:
  - Stimulus: accept 2 words, assert rst 1 cycle, then start 0x0001+0x0001.
  - Required: outputs are 0 after reset; the new result is 0x0002 with out_last on its 4th word.
- WORDS=1 build, N=4:
  - Stimulus: back-to-back 0xF+0x1, then 0x7+0x1.
  - Required: every result word has out_last=1.
  - First result: sum 0, cout 1, ovf 0. Second result: sum 8, cout 0, ovf 1.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Word-serial WORDS x N-bit add/subtract sequencer wrapped around an external
// combinational ripple-carry adder, with valid/ready streams on both sides.
module multiword_add_seq #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_last,
  output logic         out_cout,
  output logic         out_ovf
);

  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q;
  logic            opSub_q;
  logic            outValid_q;
  logic [N-1:0]    outSum_q;
  logic            outLast_q;
  logic            outCout_q;
  logic            outOvf_q;

  logic accept;
  logic opSubEff;
  logic isLast;
  logic ovf_d;

  // idx_q is 0 whenever the FSM is idle, so the last-word test is uniform.
  always_comb begin
    in_ready = !rst & (!outValid_q | out_ready);
    accept   = in_valid & in_ready;
    opSubEff = (state_q == S_IDLE) ? in_sub : opSub_q;
    add_a    = in_a;
    add_b    = opSubEff ? ~in_b : in_b;
    add_cin  = (state_q == S_IDLE) ? (opSubEff | in_cin) : carry_q;
    isLast   = (idx_q == LAST_IDX);
    ovf_d    = (in_a[N-1] == add_b[N-1]) & (add_sum[N-1] != in_a[N-1]);
    state_d  = state_q;
    idx_d    = idx_q;
    if (isLast) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      state_d = S_RUN;
      idx_d   = idx_q + IDXW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      opSub_q    <= 1'b0;
      outValid_q <= 1'b0;
      outSum_q   <= '0;
      outLast_q  <= 1'b0;
      outCout_q  <= 1'b0;
      outOvf_q   <= 1'b0;
    end else if (accept) begin
      outValid_q <= 1'b1;
      outSum_q   <= add_sum;
      outLast_q  <= isLast;
      outCout_q  <= isLast & add_cout;
      outOvf_q   <= isLast & ovf_d;
      carry_q    <= add_cout;
      if (state_q == S_IDLE && !isLast) begin
        opSub_q <= in_sub;
      end
      state_q <= state_d;
      idx_q   <= idx_d;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid = outValid_q;
  assign out_sum   = outSum_q;
  assign out_last  = outLast_q;
  assign out_cout  = outCout_q;
  assign out_ovf   = outOvf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: a 4-word instance and a 1-word
// instance, each wrapped around a behavioural adder.
module tb_multiword_add_seq;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] sum;
    logic         last;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic         inValid, inReady, inSub, inCin;
  logic [N-1:0] inA, inB, addA, addB, addSum, outSum;
  logic         addCin, addCout, outValid, outReady, outLast, outCout, outOvf;

  logic         in1Valid, in1Ready, in1Sub, in1Cin;
  logic [N-1:0] in1A, in1B, add1A, add1B, add1Sum, out1Sum;
  logic         add1Cin, add1Cout, out1Valid, out1Ready, out1Last, out1Cout, out1Ovf;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign {addCout, addSum}   = {1'b0, addA} + {1'b0, addB} + {{N{1'b0}}, addCin};
  assign {add1Cout, add1Sum} = {1'b0, add1A} + {1'b0, add1B} + {{N{1'b0}}, add1Cin};

  multiword_add_seq #(.N(N), .WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady),
    .in_a(inA), .in_b(inB), .in_sub(inSub), .in_cin(inCin),
    .add_a(addA), .add_b(addB), .add_cin(addCin),
    .add_sum(addSum), .add_cout(addCout),
    .out_valid(outValid), .out_ready(outReady), .out_sum(outSum),
    .out_last(outLast), .out_cout(outCout), .out_ovf(outOvf)
  );

  multiword_add_seq #(.N(N), .WORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1Valid), .in_ready(in1Ready),
    .in_a(in1A), .in_b(in1B), .in_sub(in1Sub), .in_cin(in1Cin),
    .add_a(add1A), .add_b(add1B), .add_cin(add1Cin),
    .add_sum(add1Sum), .add_cout(add1Cout),
    .out_valid(out1Valid), .out_ready(out1Ready), .out_sum(out1Sum),
    .out_last(out1Last), .out_cout(out1Cout), .out_ovf(out1Ovf)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Expected words of one 4-word operation, built from the hand-computed 16-bit result.
  task automatic pushOp(input logic [15:0] res, input logic cout, input logic ovf);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.sum  = res[4*i +: 4];
      e.last = (i == 3);
      e.cout = (i == 3) ? cout : 1'b0;
      e.ovf  = (i == 3) ? ovf : 1'b0;
      q4.push_back(e);
    end
  endtask

  task automatic sendWord(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic sub, input logic cin);
    int waitCycles;
    waitCycles = 0;
    inValid = 1'b1;
    inA = a;
    inB = b;
    inSub = sub;
    inCin = cin;
    @(negedge clk);
    while (!inReady && waitCycles < 50) begin
      waitCycles++;
      @(negedge clk);
    end
    if (!inReady) begin
      total++;
      bad++;
      $display("[TB] FAIL acceptTimeout: in_ready=%0b after %0d cycles, expected 1", inReady, waitCycles);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic sub,
                               input logic cin, input logic toggleSub, input logic gap);
    for (int i = 0; i < 4; i++) begin
      sendWord(a[4*i +: 4], b[4*i +: 4], (toggleSub && i > 0) ? ~sub : sub, cin);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && outValid && outReady) begin
      if (q4.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected4: got word %0h, expected no output", outSum);
      end else begin
        e4 = q4.pop_front();
        checkOutput("sum4", {28'd0, outSum}, {28'd0, e4.sum});
        checkOutput("last4", {31'd0, outLast}, {31'd0, e4.last});
        checkOutput("cout4", {31'd0, outCout}, {31'd0, e4.cout});
        checkOutput("ovf4", {31'd0, outOvf}, {31'd0, e4.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out1Valid && out1Ready) begin
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected1: got word %0h, expected no output", out1Sum);
      end else begin
        e1 = q1.pop_front();
        checkOutput("sum1", {28'd0, out1Sum}, {28'd0, e1.sum});
        checkOutput("last1", {31'd0, out1Last}, {31'd0, e1.last});
        checkOutput("cout1", {31'd0, out1Cout}, {31'd0, e1.cout});
        checkOutput("ovf1", {31'd0, out1Ovf}, {31'd0, e1.ovf});
      end
    end
  end

  initial begin
    int drainCycles;
    rst = 1'b1;
    inValid = 1'b0; inA = '0; inB = '0; inSub = 1'b0; inCin = 1'b0; outReady = 1'b1;
    in1Valid = 1'b0; in1A = '0; in1B = '0; in1Sub = 1'b0; in1Cin = 1'b0; out1Ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", {31'd0, inReady}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rstValid", {31'd0, outValid}, 32'd0);
    checkOutput("rstSum", {28'd0, outSum}, 32'd0);
    checkOutput("rstLast", {31'd0, outLast}, 32'd0);
    checkOutput("rstCout", {31'd0, outCout}, 32'd0);
    checkOutput("rstOvf", {31'd0, outOvf}, 32'd0);

    $display("[TB] add / subtract / carry vectors");
    pushOp(16'h2233, 1'b0, 1'b0);
    applyStimulus(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    pushOp(16'h0FFF, 1'b1, 1'b0);
    applyStimulus(16'h1000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    pushOp(16'h0FFF, 1'b1, 1'b0);
    applyStimulus(16'h1000, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
    pushOp(16'h8000, 1'b0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    pushOp(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    pushOp(16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    pushOp(16'hFFFF, 1'b0, 1'b0);
    applyStimulus(16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("[TB] backpressure");
    pushOp(16'h2233, 1'b0, 1'b0);
    sendWord(4'h4, 4'hF, 1'b0, 1'b0);
    inValid = 1'b1; inA = 4'h3; inB = 4'hF; inSub = 1'b0; inCin = 1'b0;
    outReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bpInReady", {31'd0, inReady}, 32'd0);
      checkOutput("bpValid", {31'd0, outValid}, 32'd1);
      checkOutput("bpSum", {28'd0, outSum}, 32'd3);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    sendWord(4'h3, 4'hF, 1'b0, 1'b0);
    sendWord(4'h2, 4'hF, 1'b0, 1'b0);
    sendWord(4'h1, 4'h0, 1'b0, 1'b0);

    $display("[TB] reset mid-operation");
    e4 = '{sum: 4'h3, last: 1'b0, cout: 1'b0, ovf: 1'b0};
    q4.push_back(e4);
    q4.push_back(e4);
    sendWord(4'h4, 4'hF, 1'b0, 1'b0);
    sendWord(4'h3, 4'hF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstInReady", {31'd0, inReady}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midRstValid", {31'd0, outValid}, 32'd0);
    checkOutput("midRstSum", {28'd0, outSum}, 32'd0);
    checkOutput("midRstLast", {31'd0, outLast}, 32'd0);
    pushOp(16'h0002, 1'b0, 1'b0);
    applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] single-word build");
    q1.push_back('{sum: 4'h0, last: 1'b1, cout: 1'b1, ovf: 1'b0});
    q1.push_back('{sum: 4'h8, last: 1'b1, cout: 1'b0, ovf: 1'b1});
    in1Valid = 1'b1; in1A = 4'hF; in1B = 4'h1;
    @(negedge clk);
    checkOutput("w1Ready0", {31'd0, in1Ready}, 32'd1);
    @(posedge clk);
    #1;
    in1A = 4'h7; in1B = 4'h1;
    @(negedge clk);
    checkOutput("w1Ready1", {31'd0, in1Ready}, 32'd1);
    @(posedge clk);
    #1;
    in1Valid = 1'b0;

    drainCycles = 0;
    while ((q4.size() != 0 || q1.size() != 0) && drainCycles < 20) begin
      drainCycles++;
      @(posedge clk);
    end
    repeat (2) @(posedge clk);
    checkOutput("q4Drained", q4.size(), 32'd0);
    checkOutput("q1Drained", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
